// File: rtl/risky_harness_pkg.sv
// Shared constants for the risky simulation harness: FSM encoding, tohost address, pass value.
// Pure declarations, no logic.
package risky_harness_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
    localparam int          PASS_VALUE      = 1;

endpackage

// File: rtl/risky_sim_harness_ctrl_if.sv
// Core-side bundle: data-memory write bus and retire strobe from the core, core reset back to it.
// Plain wires, no latency, no backpressure.
interface risky_sim_harness_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              retire;
    logic              core_rstd;

    modport master (
        output mem_we, mem_addr, mem_wdata, retire,
        input  core_rstd
    );

    modport slave (
        input  mem_we, mem_addr, mem_wdata, retire,
        output core_rstd
    );
endinterface

// File: rtl/risky_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones instead of wrapping.
// Registered output, one-cycle update latency, no backpressure.
module risky_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/risky_sim_harness_ctrl.sv
// Run controller: holds core reset, counts cycles/retires, latches tohost pass/fail or watchdog timeout.
// Result one cycle after the terminating write; no backpressure. Retire counter gated by RISKY_HARNESS_RETIRE_CNT_EN.
module risky_sim_harness_ctrl
    import risky_harness_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                CNT_W          = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(TOHOST_ADDR_DEF),
    parameter int                RESET_CYCLES   = 3,
    parameter int                TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rstd,
    risky_sim_harness_ctrl_if.slave  core,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [DATA_W-1:0]        fail_code,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [CNT_W-1:0]         retire_cnt
);
    state_e            state_q, state_d;
    logic [7:0]        hold_q, hold_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] fail_q, fail_d;

    logic in_run;
    logic term_wr;
    logic pass_hit;
    logic wd_fire;

    assign in_run   = (state_q == RUN);
    assign term_wr  = in_run && core.mem_we && (core.mem_addr == TOHOST_ADDR) && core.mem_wdata[0];
    assign pass_hit = (core.mem_wdata == DATA_W'(PASS_VALUE));
    // A termination write in the same cycle suppresses the watchdog.
    assign wd_fire  = (TIMEOUT_CYCLES != 0) && in_run && !term_wr
                      && (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        fail_d    = fail_q;
        case (state_q)
            HOLD: begin
                hold_d = hold_q + 8'd1;
                if (hold_q == 8'(RESET_CYCLES - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (term_wr) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = pass_hit;
                    fail_d  = pass_hit ? '0 : (core.mem_wdata >> 1);
                end else if (wd_fire) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    fail_d    = '0;
                end
            end
            DONE: begin
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            state_q   <= HOLD;
            hold_q    <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            fail_q    <= fail_d;
        end
    end

    // Core runs only in RUN; DONE re-asserts reset to freeze it.
    assign core.core_rstd = in_run;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign fail_code      = fail_q;

    risky_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .clr_i (rstd),
        .en_i  (in_run),
        .cnt_o (cycle_cnt)
    );

`ifdef RISKY_HARNESS_RETIRE_CNT_EN
    risky_sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .clr_i (rstd),
        .en_i  (in_run && core.retire),
        .cnt_o (retire_cnt)
    );
`else
    logic unused_retire;
    assign unused_retire = core.retire;
    assign retire_cnt    = '0;
`endif
endmodule

// File: tb/tb_risky_sim_harness_ctrl.sv
// Directed bench for the harness controller: reset sequencing, pass/fail, timeout tie, retire count, saturation.
module tb_risky_sim_harness_ctrl;
    import risky_harness_pkg::*;

`ifdef RISKY_HARNESS_RETIRE_CNT_EN
    localparam int RET_EN = 1;
`else
    localparam int RET_EN = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    risky_sim_harness_ctrl_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    risky_sim_harness_ctrl_if #(.ADDR_W(32), .DATA_W(32)) ifb ();
    risky_sim_harness_ctrl_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    logic        a_done, a_pass, a_tmo;
    logic [31:0] a_fail, a_cyc, a_ret;
    logic        b_done, b_pass, b_tmo;
    logic [31:0] b_fail, b_cyc, b_ret;
    logic        c_done, c_pass, c_tmo;
    logic [31:0] c_fail;
    logic [3:0]  c_cyc, c_ret;

    risky_sim_harness_ctrl #(.RESET_CYCLES(3)) u_a (
        .clk(clk), .rstd(rst_a), .core(ifa), .done(a_done), .pass(a_pass), .timeout(a_tmo),
        .fail_code(a_fail), .cycle_cnt(a_cyc), .retire_cnt(a_ret));

    risky_sim_harness_ctrl #(.RESET_CYCLES(3), .TIMEOUT_CYCLES(50)) u_b (
        .clk(clk), .rstd(rst_b), .core(ifb), .done(b_done), .pass(b_pass), .timeout(b_tmo),
        .fail_code(b_fail), .cycle_cnt(b_cyc), .retire_cnt(b_ret));

    risky_sim_harness_ctrl #(.CNT_W(4), .RESET_CYCLES(3), .TIMEOUT_CYCLES(0)) u_c (
        .clk(clk), .rstd(rst_c), .core(ifc), .done(c_done), .pass(c_pass), .timeout(c_tmo),
        .fail_code(c_fail), .cycle_cnt(c_cyc), .retire_cnt(c_ret));

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ecore;
        logic        edone;
        logic        epass;
        logic [31:0] efail;
        logic [31:0] ecyc;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic ecore, input logic edone,
                                 input logic epass, input logic [31:0] efail, input logic [31:0] ecyc);
        vec_t v;
        v.rst = rst; v.we = we; v.addr = addr; v.wdata = wdata;
        v.ecore = ecore; v.edone = edone; v.epass = epass; v.efail = efail; v.ecyc = ecyc;
        return v;
    endfunction

    vec_t vt[12];

    initial begin
        #100000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int  n;
        bit  found;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.mem_we = 1'b0; ifa.mem_addr = '0; ifa.mem_wdata = '0; ifa.retire = 1'b0;
        ifb.mem_we = 1'b0; ifb.mem_addr = '0; ifb.mem_wdata = '0; ifb.retire = 1'b0;
        ifc.mem_we = 1'b0; ifc.mem_addr = '0; ifc.mem_wdata = '0; ifc.retire = 1'b0;

        // Reset sequencing followed by ignored writes and a failing tohost write.
        vt[0]  = mkv(1'b1, 1'b0, 32'h0,    32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        vt[1]  = mkv(1'b1, 1'b0, 32'h0,    32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        vt[2]  = mkv(1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        vt[3]  = mkv(1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        vt[4]  = mkv(1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        vt[5]  = mkv(1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1);
        vt[6]  = mkv(1'b0, 1'b1, 32'h1000, 32'h4, 1'b1, 1'b0, 1'b0, 32'd0, 32'd2);
        vt[7]  = mkv(1'b0, 1'b1, 32'h1004, 32'h1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd3);
        vt[8]  = mkv(1'b0, 1'b0, 32'h1000, 32'h1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd4);
        vt[9]  = mkv(1'b0, 1'b1, 32'h1000, 32'h7, 1'b0, 1'b1, 1'b0, 32'd3, 32'd5);
        vt[10] = mkv(1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 1'b1, 1'b0, 32'd3, 32'd5);
        vt[11] = mkv(1'b0, 1'b1, 32'h1000, 32'h1, 1'b0, 1'b1, 1'b0, 32'd3, 32'd5);

        for (int i = 0; i < 12; i++) begin
            rst_a = vt[i].rst; ifa.mem_we = vt[i].we; ifa.mem_addr = vt[i].addr; ifa.mem_wdata = vt[i].wdata;
            tick();
            chk($sformatf("vec%0d_core_rstd", i), 64'(ifa.core_rstd), 64'(vt[i].ecore));
            chk($sformatf("vec%0d_done", i),      64'(a_done),        64'(vt[i].edone));
            chk($sformatf("vec%0d_pass", i),      64'(a_pass),        64'(vt[i].epass));
            chk($sformatf("vec%0d_timeout", i),   64'(a_tmo),         64'd0);
            chk($sformatf("vec%0d_fail_code", i), 64'(a_fail),        64'(vt[i].efail));
            chk($sformatf("vec%0d_cycle_cnt", i), 64'(a_cyc),         64'(vt[i].ecyc));
        end
        ifa.mem_we = 1'b0;

        // Pass write at cycle_cnt == 100.
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (a_cyc == 32'd100) begin found = 1'b1; break; end
            tick();
        end
        chk("pass_reach_cyc100", 64'(found), 64'd1);
        chk("pass_done_before", 64'(a_done), 64'd0);
        ifa.mem_we = 1'b1; ifa.mem_addr = 32'h1000; ifa.mem_wdata = 32'h1;
        tick();
        ifa.mem_we = 1'b0;
        chk("pass_done", 64'(a_done), 64'd1);
        chk("pass_pass", 64'(a_pass), 64'd1);
        chk("pass_fail_code", 64'(a_fail), 64'd0);
        chk("pass_core_rstd", 64'(ifa.core_rstd), 64'd0);
        chk("pass_cycle_cnt", 64'(a_cyc), 64'd101);
        tick(); tick();
        chk("pass_cycle_frozen", 64'(a_cyc), 64'd101);
        chk("pass_done_sticky", 64'(a_done), 64'd1);

        // Retire count: retire high in HOLD (ignored), then on 10 of 20 RUN cycles incl. the terminating one.
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        ifa.retire = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ifa.core_rstd) begin found = 1'b1; break; end
            tick();
        end
        chk("ret_reach_run", 64'(found), 64'd1);
        chk("ret_hold_ignored", 64'(a_ret), 64'd0);
        ifa.mem_addr = 32'h1000; ifa.mem_wdata = 32'h1;
        for (int i = 0; i < 20; i++) begin
            ifa.retire = (i % 2 == 1);
            ifa.mem_we = (i == 19);
            tick();
        end
        ifa.retire = 1'b0; ifa.mem_we = 1'b0;
        chk("ret_done", 64'(a_done), 64'd1);
        chk("ret_pass", 64'(a_pass), 64'd1);
        chk("ret_cycle_cnt", 64'(a_cyc), 64'd20);
        chk("ret_retire_cnt", 64'(a_ret), 64'(RET_EN * 10));

        // Reset in the middle of RUN, then HOLD repeats.
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ifa.core_rstd) begin found = 1'b1; break; end
            tick();
        end
        chk("mid_reach_run", 64'(found), 64'd1);
        ifa.retire = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_cycle_before", 64'(a_cyc), 64'd5);
        chk("mid_retire_before", 64'(a_ret), 64'(RET_EN * 5));
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        chk("mid_core_rstd", 64'(ifa.core_rstd), 64'd0);
        chk("mid_cycle_cnt", 64'(a_cyc), 64'd0);
        chk("mid_retire_cnt", 64'(a_ret), 64'd0);
        chk("mid_done", 64'(a_done), 64'd0);
        n = 1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ifa.core_rstd) begin found = 1'b1; break; end
            n++;
        end
        ifa.retire = 1'b0;
        chk("mid_rerun_reached", 64'(found), 64'd1);
        chk("mid_hold_len", 64'(n), 64'd3);
        chk("mid_rerun_cycle0", 64'(a_cyc), 64'd0);

        // Watchdog timeout with TIMEOUT_CYCLES = 50.
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (b_cyc == 32'd49) begin found = 1'b1; break; end
            tick();
        end
        chk("tmo_reach_49", 64'(found), 64'd1);
        chk("tmo_done_at_49", 64'(b_done), 64'd0);
        tick();
        chk("tmo_done", 64'(b_done), 64'd1);
        chk("tmo_timeout", 64'(b_tmo), 64'd1);
        chk("tmo_pass", 64'(b_pass), 64'd0);
        chk("tmo_fail_code", 64'(b_fail), 64'd0);
        chk("tmo_cycle_cnt", 64'(b_cyc), 64'd50);
        chk("tmo_core_rstd", 64'(ifb.core_rstd), 64'd0);

        // Tie: pass write exactly at cycle_cnt == 49 beats the watchdog.
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        chk("tie_reset_timeout", 64'(b_tmo), 64'd0);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (b_cyc == 32'd49) begin found = 1'b1; break; end
            tick();
        end
        chk("tie_reach_49", 64'(found), 64'd1);
        ifb.mem_we = 1'b1; ifb.mem_addr = 32'h1000; ifb.mem_wdata = 32'h1;
        tick();
        ifb.mem_we = 1'b0;
        chk("tie_done", 64'(b_done), 64'd1);
        chk("tie_pass", 64'(b_pass), 64'd1);
        chk("tie_timeout", 64'(b_tmo), 64'd0);

        // Saturation with a 4-bit counter and timeout disabled.
        rst_c = 1'b1; tick(); rst_c = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ifc.core_rstd) begin found = 1'b1; break; end
            tick();
        end
        chk("sat_reach_run", 64'(found), 64'd1);
        for (int i = 0; i < 15; i++) tick();
        chk("sat_cycle_15", 64'(c_cyc), 64'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_cycle_hold", 64'(c_cyc), 64'd15);
        chk("sat_done", 64'(c_done), 64'd0);
        chk("sat_core_rstd", 64'(ifc.core_rstd), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/risky_sim_harness_ctrl.md
Name: risky_sim_harness_ctrl

Overview:
- Synthesizable run controller for the risky core in simulation and on-board self-test.
- Sequences the core's reset, counts run cycles and retired instructions, and watches the data-memory write bus for riscv-tests "tohost" writes.
- Latches pass/fail/timeout. Replaces the fixed reset pulse and the open-ended finish delay in the benches with a parametrised, terminating mechanism.
- Sits between the top-level bench/board wrapper and the risky core plus data memory.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, data-memory write-data width.
- CNT_W, 32, width of cycle and retire counters.
- TOHOST_ADDR, 32'h0000_1000, byte address of tohost word.
- RESET_CYCLES, 3, cycles core_rstd held low after harness reset; legal range 1..255.
- TIMEOUT_CYCLES, 1_000_000, run-cycle limit; 0 disables timeout.

Ports:
- clk  in  1  system clock
- rstd  in  1  synchronous, active-high reset
- core_rstd  out  1  reset to risky core, active-low
- mem_we  in  1  core data-memory write enable
- mem_addr  in  ADDR_W  core data-memory write address
- mem_wdata  in  DATA_W  core data-memory write data
- retire  in  1  one instruction retired this cycle
- done  out  1  run terminated (sticky)
- pass  out  1  tohost value == 1 (valid when done)
- timeout  out  1  terminated by watchdog (valid when done)
- fail_code  out  DATA_W  tohost value >> 1 on failure, else 0
- cycle_cnt  out  CNT_W  RUN-state cycles elapsed
- retire_cnt  out  CNT_W  instructions retired in RUN

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high on rstd. All state is sampled on the rising edge of clk.
- Reset values: state=HOLD, core_rstd=0, done=0, pass=0, timeout=0, fail_code=0, cycle_cnt=0, retire_cnt=0, hold counter=0.
- FSM states: HOLD, RUN, DONE.
- HOLD:
  - core_rstd=0.
  - Hold counter increments each cycle.
  - When it reaches RESET_CYCLES-1 → RUN. HOLD therefore lasts exactly RESET_CYCLES cycles after rstd deasserts.
  - mem_we and retire are ignored.
- RUN:
  - core_rstd=1.
  - cycle_cnt increments every cycle.
  - retire_cnt increments when retire=1.
  - Both counters saturate at all-ones; no wrap.
- Termination write: mem_we=1, mem_addr==TOHOST_ADDR and mem_wdata[0]=1.
  - Next cycle: state=DONE, done=1, pass=(mem_wdata==1), fail_code = pass ? 0 : mem_wdata>>1.
  - Latency is 1 cycle from the write to done.
- Non-terminating writes: tohost writes with mem_wdata[0]=0 are ignored (syscall proxy unused). Writes to other addresses are ignored.
- Timeout:
  - Fires when TIMEOUT_CYCLES!=0 and cycle_cnt==TIMEOUT_CYCLES-1 while in RUN with no termination write that cycle.
  - Next cycle: DONE, done=1, timeout=1, pass=0, fail_code=0.
- Simultaneous events: a termination write and timeout in the same cycle → the termination write wins and timeout stays 0.
- DONE:
  - Absorbing.
  - core_rstd=0 (freezes the core).
  - Counters and result outputs hold their values.
  - Only rstd leaves DONE.
- Reset mid-operation: rstd=1 in any state returns to reset values on the same edge. core_rstd is low from the next cycle.
- cycle_cnt and retire_cnt are registered. The retire count of the terminating cycle is included.

Optional Feature:
- Macro: RISKY_HARNESS_RETIRE_CNT_EN.
- Defined: retire counter implemented as specified.
- Undefined: no retire counter register; retire_cnt driven constant 0. retire remains a port but is unused.

Decomposition:
- Shared package risky_harness_pkg holds:
  - state encoding constants HOLD=2'd0, RUN=2'd1, DONE=2'd2;
  - default TOHOST_ADDR;
  - PASS_VALUE=1.
- One natural sub-module: risky_sat_counter (parametrised width, enable, sync clear, saturate). Instantiated for cycle_cnt and retire_cnt.

Test Plan:
- Reset sequencing: rstd high 2 cycles then low, RESET_CYCLES=3 → core_rstd 0 for exactly 3 cycles, then 1; cycle_cnt starts 0, increments from the first RUN cycle.
- Pass: in RUN at cycle_cnt=100, write addr 0x1000 data 0x1 → next cycle done=1, pass=1, fail_code=0, core_rstd=0, cycle_cnt frozen at 101.
- Fail: write 0x1000 data 0x7 → done=1, pass=0, fail_code=3. Prior write 0x1000 data 0x4 and write 0x1004 data 0x1 → ignored, done stays 0.
- Timeout and tie: TIMEOUT_CYCLES=50, no tohost → done=1, timeout=1 one cycle after cycle_cnt=49. Rerun with tohost write 0x1 exactly at cycle_cnt=49 → pass=1, timeout=0.
- Retire count and reset mid-run: retire high on 10 of 20 run cycles, then termination write → retire_cnt=10 (0 with RISKY_HARNESS_RETIRE_CNT_EN undefined). Assert rstd mid-RUN → all outputs reset next edge; HOLD repeats for RESET_CYCLES cycles.
- Saturation: CNT_W=4, TIMEOUT_CYCLES=0, run 20 cycles → cycle_cnt holds 15, no wrap; done stays 0.
